rah_frame_uart_tx: RTL and testbench

- Downstream consumer of one rah_decoder application queue. Runs in the rx_pixel_clk domain, so the rd_clk slot for its app index is tied to rx_pixel_clk.
- Pops RAH_PACKET_WIDTH-bit packets from the queue and splits each into bytes, most significant byte first.
- Serialises every byte on a UART TX pin as 8N1.
- Gives a host-visible loopback/debug path for data that arrives over MIPI RX.

---
 rtl/rah_frame_uart_tx_pkg.sv | 23 ++
 rtl/rah_frame_uart_tx_uart_tx_byte.sv | 78 +++++++
 rtl/rah_frame_uart_tx.sv | 109 ++++++++++
 tb/tb_rah_frame_uart_tx.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rah_frame_uart_tx_pkg.sv
// rah_frame_uart_tx_pkg: shared FSM encodings and width helper for the frame-to-UART transmitter
package rah_frame_uart_tx_pkg;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_FETCH,
        FR_CAPTURE,
        FR_SEND
    } frame_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    // Counter width for n distinct values, never narrower than one bit.
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rah_frame_uart_tx_uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serialiser (start, 8 data bits LSB first, stop)
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   start         request a byte; accepted when idle or on the last stop-bit cycle
//   byte_in[7:0]  byte to send, sampled on the last cycle of the start bit
//   tx            registered serial line, idle high
//   done          high on the last cycle of the stop bit
module uart_tx_byte
    import rah_frame_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       done
);

    localparam int BW = min1_clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          last;

    assign last = baud_q == BAUD_LAST;
    assign done = (state_q == TX_STOP) && last;
    assign tx   = tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Chaining start onto the last stop cycle gives back-to-back bytes with no idle bit.
    always_comb begin
        state_d = state_q;
        baud_d  = last ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            TX_IDLE: begin
                baud_d  = '0;
                state_d = start ? TX_START : TX_IDLE;
            end
            TX_START: if (last) begin
                state_d = TX_DATA;
                shift_d = byte_in;
                bit_d   = '0;
            end
            TX_DATA: if (last) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 3'd1;
                state_d = (bit_q == 3'd7) ? TX_STOP : TX_DATA;
            end
            TX_STOP: if (last) state_d = start ? TX_START : TX_IDLE;
            default: state_d = TX_IDLE;
        endcase
        tx_d = (state_d == TX_START) ? 1'b0 : (state_d == TX_DATA) ? shift_d[0] : 1'b1;
    end

endmodule

// File: rtl/rah_frame_uart_tx.sv
// rah_frame_uart_tx: pops packets from a decoder app queue and sends them MSB byte first as 8N1 UART
// Ports:
//   clk, rst_n               rx_pixel_clk domain clock, asynchronous active-low reset
//   data_queue_empty         app queue empty flag
//   data_queue_almost_empty  accepted for port compatibility, not used
//   data_frame               queue read data, valid the cycle after request_data
//   request_data             one-cycle pop strobe
//   uart_tx_pin              serial output, idle high
//   busy                     high whenever the frame FSM is not idle
//   frame_count              packets fully transmitted, wraps at 16'hFFFF
module rah_frame_uart_tx
    import rah_frame_uart_tx_pkg::*;
#(
    parameter int RAH_PACKET_WIDTH = 48,
    parameter int CLKS_PER_BIT     = 868
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        data_queue_empty,
    input  logic                        data_queue_almost_empty,
    input  logic [RAH_PACKET_WIDTH-1:0] data_frame,
    output logic                        request_data,
    output logic                        uart_tx_pin,
    output logic                        busy,
    output logic [15:0]                 frame_count
);

    localparam int BYTES_PER_FRAME = RAH_PACKET_WIDTH / 8;
    localparam int IW = min1_clog2(BYTES_PER_FRAME);
    localparam logic [IW-1:0] IDX_LAST = IW'(BYTES_PER_FRAME - 1);

    frame_state_e                state_q, state_d;
    logic [RAH_PACKET_WIDTH-1:0] frame_q, frame_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [15:0]                 frame_count_q, frame_count_d;
    logic                        request_data_q, busy_q;
    logic                        start, done;
    logic [7:0]                  frame_bytes [BYTES_PER_FRAME];
    logic                        unused;

    assign unused       = data_queue_almost_empty;
    assign request_data = request_data_q;
    assign busy         = busy_q;
    assign frame_count  = frame_count_q;

    // Byte 0 is the most significant byte of the packet.
    for (genvar g = 0; g < BYTES_PER_FRAME; g++) begin : g_bytes
        assign frame_bytes[g] = frame_q[RAH_PACKET_WIDTH-1-8*g -: 8];
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .byte_in(frame_bytes[idx_q]),
        .tx     (uart_tx_pin),
        .done   (done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= FR_IDLE;
            frame_q        <= '0;
            idx_q          <= '0;
            frame_count_q  <= '0;
            request_data_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_q        <= frame_d;
            idx_q          <= idx_d;
            frame_count_q  <= frame_count_d;
            request_data_q <= state_d == FR_FETCH;
            busy_q         <= state_d != FR_IDLE;
        end
    end

    // start is combinational so the byte engine leaves idle on the edge that ends CAPTURE.
    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        idx_d         = idx_q;
        frame_count_d = frame_count_q;
        start         = 1'b0;
        case (state_q)
            FR_IDLE:  state_d = data_queue_empty ? FR_IDLE : FR_FETCH;
            FR_FETCH: state_d = FR_CAPTURE;
            FR_CAPTURE: begin
                frame_d = data_frame;
                idx_d   = '0;
                start   = 1'b1;
                state_d = FR_SEND;
            end
            FR_SEND: if (done) begin
                if (idx_q < IDX_LAST) begin
                    idx_d = idx_q + 1'b1;
                    start = 1'b1;
                end else begin
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = FR_IDLE;
                end
            end
            default: state_d = FR_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rah_frame_uart_tx.sv
module tb_rah_frame_uart_tx;

    localparam int C = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        data_queue_empty = 1'b1;
    logic        data_queue_almost_empty = 1'b0;
    logic [47:0] data_frame = '0;
    logic        request_data, uart_tx_pin, busy;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    rah_frame_uart_tx #(
        .RAH_PACKET_WIDTH(48),
        .CLKS_PER_BIT    (C)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .data_queue_empty       (data_queue_empty),
        .data_queue_almost_empty(data_queue_almost_empty),
        .data_frame             (data_frame),
        .request_data           (request_data),
        .uart_tx_pin            (uart_tx_pin),
        .busy                   (busy),
        .frame_count            (frame_count)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [47:0] src_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];
    int          gap_q[$];
    longint      start_t_q[$];
    longint      cyc = 0;
    int          pops = 0;
    int          pop_err = 0;
    int          req_long = 0;
    int          frame_err = 0;
    logic        req_prev = 1'b0;
    logic        empty_force = 1'b0;
    logic        mon_act = 1'b0;
    int          mon_cnt = 0;
    int          hi_run = 0;
    logic [7:0]  mon_sh = '0;

    always @(posedge clk) cyc++;

    // Queue model: a pop seen in FETCH presents data for the following CAPTURE cycle.
    always @(negedge clk) begin
        if (rst_n && request_data) begin
            pops++;
            if (src_q.size() == 0) pop_err++;
            else data_frame = src_q.pop_front();
        end
        if (request_data && req_prev) req_long++;
        req_prev = request_data;
        data_queue_empty = (src_q.size() == 0) || empty_force;
    end

    // Line decoder: samples each bit in its middle and records the idle run before every start bit.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_act = 1'b0;
            hi_run = 0;
        end else if (!mon_act) begin
            if (uart_tx_pin == 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 1;
                gap_q.push_back(hi_run);
                start_t_q.push_back(cyc);
                hi_run = 0;
            end else hi_run++;
        end else begin
            if (mon_cnt % C == C / 2) begin
                if (mon_cnt / C == 0) begin
                    if (uart_tx_pin !== 1'b0) frame_err++;
                end else if (mon_cnt / C <= 8) mon_sh[mon_cnt/C-1] = uart_tx_pin;
                else begin
                    if (uart_tx_pin !== 1'b1) frame_err++;
                    rx_q.push_back(mon_sh);
                    mon_act = 1'b0;
                    hi_run = C / 2 + 1;
                end
            end
            mon_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_frame(input logic [47:0] f);
        src_q.push_back(f);
        for (int i = 5; i >= 0; i--) exp_q.push_back(f[8*i +: 8]);
    endtask

    task automatic wait_count(input logic [15:0] v, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_count == v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_obs();
        rx_q.delete();
        gap_q.delete();
        start_t_q.delete();
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        #2 rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (uart_tx_pin !== 1'b1 || request_data !== 1'b0 || busy !== 1'b0 || frame_count !== 16'd0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL reset_hold: %0d bad cycles, want 0", bad); end
        n_checks++;
        if (uart_tx_pin !== 1'b1) begin n_fail++; $display("FAIL reset_pin: got %b want 1", uart_tx_pin); end
        n_checks++;
        if (request_data !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", request_data); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++;
        if (frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", frame_count); end
    endtask

    task automatic test_single_frame();
        int  base;
        bit  ok;
        logic [7:0] got, exp;
        base = pops;
        clear_obs();
        push_frame(48'hA1B2C3D4E5F6);
        wait_count(16'd1, 2000, ok);
        tick(5);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_done: frame_count %0d want 1 (timeout)", frame_count); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (rx_q.size() == 0 || exp_q.size() == 0) begin
                n_fail++; $display("FAIL single_byte%0d: missing (rx %0d exp %0d)", i, rx_q.size(), exp_q.size());
            end else begin
                got = rx_q.pop_front(); exp = exp_q.pop_front();
                if (got !== exp) begin n_fail++; $display("FAIL single_byte%0d: got %h want %h", i, got, exp); end
            end
        end
        n_checks++;
        if (pops != base + 1) begin n_fail++; $display("FAIL single_pops: got %0d want %0d", pops - base, 1); end
        n_checks++;
        if (start_t_q.size() != 6) begin n_fail++; $display("FAIL single_starts: got %0d want 6", start_t_q.size()); end
        else if (start_t_q[5] - start_t_q[0] + 10 * C != 240) begin
            n_fail++; $display("FAIL single_duration: got %0d want 240", start_t_q[5] - start_t_q[0] + 10 * C);
        end
        n_checks++;
        if (frame_err != 0 || req_long != 0 || pop_err != 0) begin
            n_fail++; $display("FAIL single_framing: frame_err %0d req_long %0d pop_err %0d want 0", frame_err, req_long, pop_err);
        end
        n_checks++;
        if (busy !== 1'b0 || frame_count !== 16'd1) begin
            n_fail++; $display("FAIL single_final: busy %b count %0d want 0/1", busy, frame_count);
        end
    endtask

    task automatic test_back_to_back();
        int  base;
        bit  ok;
        logic [7:0] got, exp;
        base = pops;
        clear_obs();
        push_frame(48'h000000000001);
        push_frame(48'hFFFFFFFFFFFF);
        wait_count(16'd3, 4000, ok);
        tick(5);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_done: frame_count %0d want 3 (timeout)", frame_count); end
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (rx_q.size() == 0 || exp_q.size() == 0) begin
                n_fail++; $display("FAIL b2b_byte%0d: missing (rx %0d exp %0d)", i, rx_q.size(), exp_q.size());
            end else begin
                got = rx_q.pop_front(); exp = exp_q.pop_front();
                if (got !== exp) begin n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, got, exp); end
            end
        end
        n_checks++;
        if (pops != base + 2) begin n_fail++; $display("FAIL b2b_pops: got %0d want 2", pops - base); end
        n_checks++;
        if (gap_q.size() != 12) begin n_fail++; $display("FAIL b2b_starts: got %0d want 12", gap_q.size()); end
        else begin
            if (gap_q[1] != C) begin n_fail++; $display("FAIL b2b_byte_gap: got %0d want %0d", gap_q[1], C); end
            n_checks++;
            if (gap_q[6] != C + 3) begin n_fail++; $display("FAIL b2b_frame_gap: got %0d want %0d", gap_q[6], C + 3); end
        end
        n_checks++;
        if (frame_count !== 16'd3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", frame_count); end
    endtask

    task automatic test_empty_pulse();
        int  base;
        bit  ok;
        logic [7:0] got, exp;
        base = pops;
        clear_obs();
        push_frame(48'h123456789ABC);
        push_frame(48'h0F1E2D3C4B5A);
        for (int i = 0; i < 2000 && rx_q.size() < 2; i++) tick(1);
        empty_force = 1'b1;
        tick(3 * C);
        empty_force = 1'b0;
        wait_count(16'd4, 2000, ok);
        n_checks++;
        if (!ok || pops != base + 1) begin
            n_fail++; $display("FAIL empty_pulse_pops: done %0d pops %0d want 1", ok, pops - base);
        end
        wait_count(16'd5, 2000, ok);
        tick(5);
        n_checks++;
        if (!ok || pops != base + 2) begin
            n_fail++; $display("FAIL empty_pulse_second: done %0d pops %0d want 2", ok, pops - base);
        end
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (rx_q.size() == 0 || exp_q.size() == 0) begin
                n_fail++; $display("FAIL empty_byte%0d: missing (rx %0d exp %0d)", i, rx_q.size(), exp_q.size());
            end else begin
                got = rx_q.pop_front(); exp = exp_q.pop_front();
                if (got !== exp) begin n_fail++; $display("FAIL empty_byte%0d: got %h want %h", i, got, exp); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int  base;
        bit  ok;
        logic [7:0] got, exp;
        clear_obs();
        push_frame(48'h5500AA55AA55);
        for (int i = 0; i < 2000 && rx_q.size() < 1; i++) tick(1);
        tick(10);
        n_checks++;
        if (uart_tx_pin !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre: pin %b busy %b want 0/1", uart_tx_pin, busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (uart_tx_pin !== 1'b1) begin n_fail++; $display("FAIL mid_async_pin: got %b want 1", uart_tx_pin); end
        n_checks++;
        if (busy !== 1'b0 || frame_count !== 16'd0) begin
            n_fail++; $display("FAIL mid_async_state: busy %b count %0d want 0/0", busy, frame_count);
        end
        tick(2);
        clear_obs();
        exp_q.delete();
        base = pops;
        push_frame(48'hC0FFEE123456);
        tick(1);
        rst_n = 1'b1;
        wait_count(16'd1, 2000, ok);
        tick(5);
        n_checks++;
        if (!ok || pops != base + 1) begin
            n_fail++; $display("FAIL mid_refetch: done %0d pops %0d want 1", ok, pops - base);
        end
        n_checks++;
        if (rx_q.size() != 6) begin n_fail++; $display("FAIL mid_len: got %0d bytes want 6", rx_q.size()); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (rx_q.size() == 0 || exp_q.size() == 0) begin
                n_fail++; $display("FAIL mid_byte%0d: missing (rx %0d exp %0d)", i, rx_q.size(), exp_q.size());
            end else begin
                got = rx_q.pop_front(); exp = exp_q.pop_front();
                if (got !== exp) begin n_fail++; $display("FAIL mid_byte%0d: got %h want %h", i, got, exp); end
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        for (int i = 0; i < 2000 && busy; i++) tick(1);
        force dut.frame_count_q = 16'hFFFF;
        tick(1);
        release dut.frame_count_q;
        tick(1);
        n_checks++;
        if (frame_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffff", frame_count); end
        clear_obs();
        exp_q.delete();
        push_frame(48'h0102A0B0C0D0);
        wait_count(16'd0, 2000, ok);
        tick(5);
        n_checks++;
        if (!ok || frame_count !== 16'd0) begin
            n_fail++; $display("FAIL wrap_count: done %0d got %h want 0000", ok, frame_count);
        end
        n_checks++;
        if (rx_q.size() != 6 || rx_q[5] !== 8'hD0) begin
            n_fail++; $display("FAIL wrap_bytes: got %0d bytes, want 6 ending d0", rx_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_empty_pulse();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
